// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan display: active-low glyphs,
// anode-off pattern and scan index width.
package seg7_pkg;

    localparam int unsigned IDX_W = 2;

    // Active-low glyphs with seg[0]=a ... seg[6]=g and seg[7]=dp (off).
    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [3:0] AN_OFF   = 4'hF;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment glyph (a..g).
// Non-BCD codes 10..15 render as a dash.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_DASH[6:0];
        case (nibble)
            4'd0:    glyph = SEG_0[6:0];
            4'd1:    glyph = SEG_1[6:0];
            4'd2:    glyph = SEG_2[6:0];
            4'd3:    glyph = SEG_3[6:0];
            4'd4:    glyph = SEG_4[6:0];
            4'd5:    glyph = SEG_5[6:0];
            4'd6:    glyph = SEG_6[6:0];
            4'd7:    glyph = SEG_7[6:0];
            4'd8:    glyph = SEG_8[6:0];
            4'd9:    glyph = SEG_9[6:0];
            default: glyph = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed MM:SS driver for a 4-digit common-anode display with
// per-slot anti-ghost blanking and adjust-mode blinking.
// Optional macro SEG7_COLON_DP_EN lights the decimal point on digit 2.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_DIV    = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic        blink_en,
    input  logic        blink_sel,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);

    logic [RW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic             sel_q, sel_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             phase_q, phase_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic             term;
    logic             in_pair;
    logic             blank;
    logic [3:0]       nibble;
    logic [6:0]       glyph;

    seg7_decoder u_dec (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        term    = (cnt_q == RW'(REFRESH_DIV - 1));
        cnt_d   = term ? '0 : cnt_q + 1'b1;
        idx_d   = term ? idx_q + 1'b1 : idx_q;
        // Capture only at frame end so a whole frame shows one value.
        snap_d  = (term && idx_q == '1) ? digits : snap_q;
        // blink_sel is sampled per slot so a slot is never split mid-way.
        sel_d   = term ? blink_sel : sel_q;

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!blink_en) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + 1'b1;
        end

        nibble  = snap_q[{idx_q, 2'b00} +: 4];
        in_pair = sel_q ? ~idx_q[1] : idx_q[1];
        blank   = (cnt_q < RW'(BLANK_CYCLES)) || (phase_q && in_pair);

        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        if (!blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = {1'b1, glyph};
`ifdef SEG7_COLON_DP_EN
            seg_d[7] = (idx_q != 2'd2);
`else
            seg_d[7] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            sel_q   <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            sel_q   <= sel_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2,
// BLINK_DIV=64; honours SEG7_COLON_DP_EN when defined.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic        blink_en;
    logic        blink_sel;
    logic [3:0]  an;
    logic [7:0]  seg;

    int tests;
    int fails;

    seg7_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .BLINK_DIV    (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    (digits),
        .blink_en  (blink_en),
        .blink_sel (blink_sel),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: an got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: seg got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] with_dp(input int idx, input logic [7:0] g);
`ifdef SEG7_COLON_DP_EN
        return (idx == 2) ? (g & 8'h7F) : g;
`else
        return g;
`endif
    endfunction

    // One 8-cycle slot: first two cycles blank, then the glyph unless blinked off.
    task automatic check_slot(input string tag, input int idx, input logic [7:0] g, input bit off);
        logic [3:0] an_exp;
        an_exp = 4'(~(4'b0001 << idx));
        for (int t = 0; t < 8; t++) begin
            tick();
            if (t < 2 || off) begin
                chk4($sformatf("%s idx%0d t%0d", tag, idx, t), an, 4'hF);
                chk8($sformatf("%s idx%0d t%0d", tag, idx, t), seg, 8'hFF);
            end else begin
                chk4($sformatf("%s idx%0d t%0d", tag, idx, t), an, an_exp);
                chk8($sformatf("%s idx%0d t%0d", tag, idx, t), seg, with_dp(idx, g));
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] g0, input logic [7:0] g1,
                               input logic [7:0] g2, input logic [7:0] g3,
                               input bit off_lo, input bit off_hi);
        check_slot(tag, 0, g0, off_lo);
        check_slot(tag, 1, g1, off_lo);
        check_slot(tag, 2, g2, off_hi);
        check_slot(tag, 3, g3, off_hi);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        digits    = 16'h1234;
        blink_en  = 1'b0;
        blink_sel = 1'b0;

        repeat (3) tick();
        chk4("reset", an, 4'hF);
        chk8("reset", seg, 8'hFF);

        rst_n = 1'b1;
        check_frame("frame0 zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, 1'b0);
        check_frame("frame1 1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 1'b0);

        // Change input while index 1 is being scanned; frame must not tear.
        check_slot("frame2 hold", 0, 8'h99, 1'b0);
        digits = 16'h5678;
        check_slot("frame2 hold", 1, 8'hB0, 1'b0);
        check_slot("frame2 hold", 2, 8'hA4, 1'b0);
        check_slot("frame2 hold", 3, 8'hF9, 1'b0);
        check_frame("frame3 5678", 8'h80, 8'hF8, 8'h82, 8'h92, 1'b0, 1'b0);

        digits = 16'hFA00;
        check_frame("frame4 5678", 8'h80, 8'hF8, 8'h82, 8'h92, 1'b0, 1'b0);

        digits    = 16'h0959;
        blink_sel = 1'b1;
        check_frame("frame5 dash", 8'hC0, 8'hC0, 8'hBF, 8'hBF, 1'b0, 1'b0);

        blink_en = 1'b1;
        check_frame("blink vis a", 8'h90, 8'h92, 8'h90, 8'hC0, 1'b0, 1'b0);
        check_frame("blink vis b", 8'h90, 8'h92, 8'h90, 8'hC0, 1'b0, 1'b0);
        check_frame("blink off a", 8'h90, 8'h92, 8'h90, 8'hC0, 1'b1, 1'b0);
        check_frame("blink off b", 8'h90, 8'h92, 8'h90, 8'hC0, 1'b1, 1'b0);
        check_frame("blink vis c", 8'h90, 8'h92, 8'h90, 8'hC0, 1'b0, 1'b0);
        check_frame("blink vis d", 8'h90, 8'h92, 8'h90, 8'hC0, 1'b0, 1'b0);

        // Phase has just gone invisible; dropping blink_en must restore display.
        blink_en = 1'b0;
        check_frame("blink exit", 8'h90, 8'h92, 8'h90, 8'hC0, 1'b0, 1'b0);

        repeat (5) tick();
        rst_n = 1'b0;
        #2;
        chk4("async reset", an, 4'hF);
        chk8("async reset", seg, 8'hFF);
        tick();
        rst_n = 1'b1;
        check_frame("restart", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
